// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/stall handshake bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = pipeline side (raises hazards), slave = hazard controller (drives stall/flush).
interface pipe_hazard_ctrl_if;
    logic       load_use;
    logic       ex_start;
    logic       mem_req;
    logic       mem_ack;
    logic       branch_taken;
    logic [4:0] stall;
    logic [4:0] flush;
    logic       busy;

    modport master (
        output load_use, ex_start, mem_req, mem_ack, branch_taken,
        input  stall, flush, busy
    );

    modport slave (
        input  load_use, ex_start, mem_req, mem_ack, branch_taken,
        output stall, flush, busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// Optional perf counters are built only when STALL_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT_CYCLES = 4,
    parameter int DIV_CYCLES      = 32,
    parameter int CNT_W           = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    hz,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        EX_WAIT  = 2'd2
    } state_t;

    // cnt holds the wait cycles still to come after the current one, so a wait state exits when it reads 0.
    // The detection cycle in RUN already stalls, hence the "-2" loads when entering from RUN.
    localparam logic [CNT_W-1:0] MEM_FIRST = CNT_W'((MEM_WAIT_CYCLES > 1) ? MEM_WAIT_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_FIRST = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_CHAIN = CNT_W'((DIV_CYCLES > 0) ? DIV_CYCLES - 1 : 0);

    localparam logic [4:0] STALL_MEM = 5'b01111;
    localparam logic [4:0] FLUSH_MEM = 5'b10000;
    localparam logic [4:0] STALL_EX  = 5'b00111;
    localparam logic [4:0] FLUSH_EX  = 5'b01000;
    localparam logic [4:0] STALL_LU  = 5'b00011;
    localparam logic [4:0] FLUSH_LU  = 5'b00100;
    localparam logic [4:0] FLUSH_BR  = 5'b00010;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pend_ex;
    logic             pend_nxt;
    logic [4:0]       stall_mask;
    logic [4:0]       flush_mask;
    logic             busy_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            cnt     <= '0;
            pend_ex <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_ex <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend_ex;
        case (state)
            RUN: begin
                if (hz.mem_req) begin
                    if (MEM_WAIT_CYCLES > 1) begin
                        state_nxt = MEM_WAIT;
                        cnt_nxt   = MEM_FIRST;
                        pend_nxt  = hz.ex_start;
                    end else if (hz.ex_start) begin
                        // The MEM wait is over already, so the queued op gets its full DIV_CYCLES here.
                        state_nxt = EX_WAIT;
                        cnt_nxt   = DIV_CHAIN;
                    end
                end else if (hz.ex_start && (DIV_CYCLES > 1)) begin
                    state_nxt = EX_WAIT;
                    cnt_nxt   = DIV_FIRST;
                end
            end
            MEM_WAIT: begin
                if ((cnt == '0) || hz.mem_ack) begin
                    state_nxt = pend_ex ? EX_WAIT : RUN;
                    cnt_nxt   = pend_ex ? DIV_CHAIN : '0;
                    pend_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            EX_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    // load_use outranks branch_taken: the branch re-resolves once the bubble has passed.
    always_comb begin
        stall_mask = '0;
        flush_mask = '0;
        busy_flag  = 1'b0;
        if (rst) begin
            flush_mask = '1;
        end else begin
            case (state)
                RUN: begin
                    if (hz.mem_req) begin
                        stall_mask = STALL_MEM;
                        flush_mask = FLUSH_MEM;
                    end else if (hz.ex_start) begin
                        stall_mask = STALL_EX;
                        flush_mask = FLUSH_EX;
                    end else if (hz.load_use) begin
                        stall_mask = STALL_LU;
                        flush_mask = FLUSH_LU;
                    end else if (hz.branch_taken) begin
                        flush_mask = FLUSH_BR;
                    end
                end
                MEM_WAIT: begin
                    stall_mask = STALL_MEM;
                    flush_mask = FLUSH_MEM;
                    busy_flag  = 1'b1;
                end
                EX_WAIT: begin
                    stall_mask = STALL_EX;
                    flush_mask = FLUSH_EX;
                    busy_flag  = 1'b1;
                end
                default: begin
                    stall_mask = '0;
                    flush_mask = '0;
                    busy_flag  = 1'b0;
                end
            endcase
        end
    end

    assign hz.stall = stall_mask;
    assign hz.flush = flush_mask;
    assign hz.busy  = busy_flag;

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (|stall_mask) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush_mask[1] || flush_mask[2]) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard priorities, wait lengths, chaining and reset abandonment.
// Perf-counter expectations follow STALL_PERF_CNT_EN in the same way the design does.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    int          checks;
    int          errors;
    int          n;
    int          nb;

    pipe_hazard_ctrl_if hif ();

    pipe_hazard_ctrl #(
        .MEM_WAIT_CYCLES (4),
        .DIV_CYCLES      (32),
        .CNT_W           (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hz           (hif),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: change inputs just after the edge, then settle so outputs can be sampled mid-cycle.
    task automatic applyStimulus(input logic r, input logic lu, input logic ex,
                                 input logic mr, input logic ma, input logic bt);
        @(posedge clk);
        #1;
        rst              = r;
        hif.load_use     = lu;
        hif.ex_start     = ex;
        hif.mem_req      = mr;
        hif.mem_ack      = ma;
        hif.branch_taken = bt;
        #2;
    endtask

    task automatic countRun(input logic [4:0] sp, input logic [4:0] fp, output int len, output int nbusy);
        len   = 0;
        nbusy = 0;
        while (hif.stall === sp && hif.flush === fp && len < 200) begin
            len++;
            if (hif.busy === 1'b1) nbusy++;
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        hif.load_use     = 1'b0;
        hif.ex_start     = 1'b0;
        hif.mem_req      = 1'b0;
        hif.mem_ack      = 1'b0;
        hif.branch_taken = 1'b0;

        applyStimulus(1, 1, 0, 0, 0, 1);
        checkOutput("rst_stall", 32'(hif.stall), 32'h00);
        checkOutput("rst_flush", 32'(hif.flush), 32'h1F);
        checkOutput("rst_busy",  32'(hif.busy),  32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("idle_stall", 32'(hif.stall), 32'h00);
        checkOutput("idle_flush", 32'(hif.flush), 32'h00);

        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("lu_stall", 32'(hif.stall), 32'h03);
        checkOutput("lu_flush", 32'(hif.flush), 32'h04);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("lu_after_stall", 32'(hif.stall), 32'h00);
        checkOutput("lu_after_busy",  32'(hif.busy),  32'h0);

        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("br_stall", 32'(hif.stall), 32'h00);
        checkOutput("br_flush", 32'(hif.flush), 32'h02);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("lu_br_stall", 32'(hif.stall), 32'h03);
        checkOutput("lu_br_flush", 32'(hif.flush), 32'h04);

        // mem_req with lower-priority hazards alongside; ack in the same cycle must be ignored
        applyStimulus(0, 1, 0, 1, 1, 1);
        checkOutput("mem_first_busy", 32'(hif.busy), 32'h0);
        countRun(5'b01111, 5'b10000, n, nb);
        checkOutput("mem_len", 32'(n), 32'd4);
        checkOutput("mem_busy_len", 32'(nb), 32'd3);
        checkOutput("mem_after_stall", 32'(hif.stall), 32'h00);
        checkOutput("mem_after_busy",  32'(hif.busy),  32'h0);

        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("ack_c1_stall", 32'(hif.stall), 32'h0F);
        applyStimulus(0, 1, 1, 0, 1, 1);
        checkOutput("ack_c2_stall", 32'(hif.stall), 32'h0F);
        checkOutput("ack_c2_flush", 32'(hif.flush), 32'h10);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ack_after_stall", 32'(hif.stall), 32'h00);
        checkOutput("ack_after_busy",  32'(hif.busy),  32'h0);

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("ex_first_busy", 32'(hif.busy), 32'h0);
        countRun(5'b00111, 5'b01000, n, nb);
        checkOutput("ex_len", 32'(n), 32'd32);
        checkOutput("ex_busy_len", 32'(nb), 32'd31);
        checkOutput("ex_after_stall", 32'(hif.stall), 32'h00);
        checkOutput("ex_after_busy",  32'(hif.busy),  32'h0);
`ifdef STALL_PERF_CNT_EN
        checkOutput("perf_stall_ex", stall_cycles, 32'd32);
        checkOutput("perf_flush_ex", flush_count,  32'd0);
`else
        checkOutput("perf_stall_off", stall_cycles, 32'd0);
        checkOutput("perf_flush_off", flush_count,  32'd0);
`endif

        applyStimulus(0, 0, 1, 1, 0, 0);
        countRun(5'b01111, 5'b10000, n, nb);
        checkOutput("chain_mem_len", 32'(n), 32'd4);
        countRun(5'b00111, 5'b01000, n, nb);
        checkOutput("chain_ex_len", 32'(n), 32'd32);
        checkOutput("chain_ex_busy", 32'(nb), 32'd32);
        checkOutput("chain_after_stall", 32'(hif.stall), 32'h00);

        // ex_start outranks load_use; then reset lands in the 10th stall cycle
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("rst6_c1_stall", 32'(hif.stall), 32'h07);
        checkOutput("rst6_c1_flush", 32'(hif.flush), 32'h08);
        for (int i = 2; i <= 9; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst6_c9_busy", 32'(hif.busy), 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst6_c10_stall", 32'(hif.stall), 32'h00);
        checkOutput("rst6_c10_flush", 32'(hif.flush), 32'h1F);
        checkOutput("rst6_c10_busy",  32'(hif.busy),  32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst6_c11_stall", 32'(hif.stall), 32'h00);
        checkOutput("rst6_c11_flush", 32'(hif.flush), 32'h00);
        checkOutput("rst6_c11_busy",  32'(hif.busy),  32'h0);
        checkOutput("rst6_perf_stall", stall_cycles, 32'd0);
        checkOutput("rst6_perf_flush", flush_count,  32'd0);

        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef STALL_PERF_CNT_EN
        checkOutput("perf_stall_mix", stall_cycles, 32'd2);
        checkOutput("perf_flush_mix", flush_count,  32'd3);
`else
        checkOutput("perf_stall_mix_off", stall_cycles, 32'd0);
        checkOutput("perf_flush_mix_off", flush_count,  32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
